// File: rtl/race_ctrl.sv
// Two-player drag-race controller: countdown lights, throttle speed with decay,
// per-frame car positions and winner/false-start detection.
module race_ctrl #(
  parameter int X_START      = 256,
  parameter int X_FINISH     = 960,
  parameter int COUNT_FRAMES = 60,
  parameter int DECAY_FRAMES = 8,
  parameter int SPEED_STEP   = 2,
  parameter int SPEED_MAX    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        start,
  input  logic        p1_key,
  input  logic        p2_key,
  output logic [10:0] xpos_p1,
  output logic [10:0] xpos_p2,
  output logic [1:0]  lights,
  output logic [1:0]  race_state,
  output logic [1:0]  winner,
  output logic        false_start
);

  localparam int SW = $clog2(SPEED_MAX + 1);
  localparam int CW = $clog2(COUNT_FRAMES + 1);
  localparam int DW = $clog2(DECAY_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            vsync_reg, armed_reg;
  logic [10:0]     xpos1_reg, xpos1_next, xpos2_reg, xpos2_next;
  logic [SW-1:0]   speed1_reg, speed1_next, speed2_reg, speed2_next;
  logic [1:0]      lights_reg, lights_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [DW-1:0]   decay_reg, decay_next;
  logic [1:0]      winner_reg, winner_next;
  logic            fs_reg, fs_next;

  logic            frame_tick, decay_now, fin1, fin2;
  logic [11:0]     sum1, sum2;

  // armed_reg blocks a tick from a vsync that was already high when reset released
  assign frame_tick = vsync_in & ~vsync_reg & armed_reg;
  assign decay_now  = frame_tick && (decay_reg == DW'(DECAY_FRAMES - 1));
  assign sum1       = {1'b0, xpos1_reg} + 12'(speed1_reg);
  assign sum2       = {1'b0, xpos2_reg} + 12'(speed2_reg);
  assign fin1       = sum1 >= 12'(X_FINISH);
  assign fin2       = sum2 >= 12'(X_FINISH);

  function automatic logic [SW-1:0] speed_up(input logic [SW-1:0] s);
    logic [11:0] sum;
    sum = 12'(s) + 12'(SPEED_STEP);
    return (sum > 12'(SPEED_MAX)) ? SW'(SPEED_MAX) : SW'(sum);
  endfunction

  function automatic logic [SW-1:0] speed_down(input logic [SW-1:0] s);
    return (s == '0) ? s : s - SW'(1);
  endfunction

  always_comb begin
    state_next  = state_reg;
    xpos1_next  = xpos1_reg;
    xpos2_next  = xpos2_reg;
    speed1_next = speed1_reg;
    speed2_next = speed2_reg;
    lights_next = lights_reg;
    cnt_next    = cnt_reg;
    decay_next  = decay_reg;
    winner_next = winner_reg;
    fs_next     = fs_reg;
    case (state_reg)
      IDLE: begin
        xpos1_next  = 11'(X_START);
        xpos2_next  = 11'(X_START);
        speed1_next = '0;
        speed2_next = '0;
        lights_next = 2'd0;
        winner_next = 2'd0;
        fs_next     = 1'b0;
        if (start) begin
          state_next  = COUNTDOWN;
          lights_next = 2'd3;
          cnt_next    = '0;
          decay_next  = '0;
        end
      end
      COUNTDOWN: begin
        if (p1_key || p2_key) begin
          state_next  = FINISH;
          fs_next     = 1'b1;
          winner_next = {p1_key, p2_key};  // the player who did not jump wins
        end else if (frame_tick) begin
          if (cnt_reg == CW'(COUNT_FRAMES - 1)) begin
            cnt_next = '0;
            if (lights_reg == 2'd1) begin
              state_next  = RACE;
              lights_next = 2'd0;
              decay_next  = '0;
            end else begin
              lights_next = lights_reg - 2'd1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      RACE: begin
        if (frame_tick)
          decay_next = decay_now ? '0 : decay_reg + DW'(1);
        if (p1_key)         speed1_next = speed_up(speed1_reg);
        else if (decay_now) speed1_next = speed_down(speed1_reg);
        if (p2_key)         speed2_next = speed_up(speed2_reg);
        else if (decay_now) speed2_next = speed_down(speed2_reg);
        if (frame_tick) begin
          xpos1_next = fin1 ? 11'(X_FINISH) : sum1[10:0];
          xpos2_next = fin2 ? 11'(X_FINISH) : sum2[10:0];
          if (fin1 || fin2) begin
            state_next  = FINISH;
            winner_next = {fin2, fin1};
            fs_next     = 1'b0;
          end
        end
      end
      FINISH: begin
        if (start) begin
          state_next  = IDLE;
          xpos1_next  = 11'(X_START);
          xpos2_next  = 11'(X_START);
          speed1_next = '0;
          speed2_next = '0;
          lights_next = 2'd0;
          winner_next = 2'd0;
          fs_next     = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      vsync_reg  <= 1'b0;
      armed_reg  <= 1'b0;
      xpos1_reg  <= 11'(X_START);
      xpos2_reg  <= 11'(X_START);
      speed1_reg <= '0;
      speed2_reg <= '0;
      lights_reg <= 2'd0;
      cnt_reg    <= '0;
      decay_reg  <= '0;
      winner_reg <= 2'd0;
      fs_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      vsync_reg  <= vsync_in;
      armed_reg  <= armed_reg | ~vsync_in;
      xpos1_reg  <= xpos1_next;
      xpos2_reg  <= xpos2_next;
      speed1_reg <= speed1_next;
      speed2_reg <= speed2_next;
      lights_reg <= lights_next;
      cnt_reg    <= cnt_next;
      decay_reg  <= decay_next;
      winner_reg <= winner_next;
      fs_reg     <= fs_next;
    end
  end

  assign xpos_p1     = xpos1_reg;
  assign xpos_p2     = xpos2_reg;
  assign lights      = lights_reg;
  assign race_state  = state_reg;
  assign winner      = winner_reg;
  assign false_start = fs_reg;

endmodule

// File: tb/tb_race_ctrl.sv
// Directed bench for race_ctrl: countdown, false starts, racing, decay and reset.
module tb_race_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync_in = 1'b0;
  logic        start = 1'b0;
  logic        p1_key = 1'b0;
  logic        p2_key = 1'b0;
  logic [10:0] xpos_p1, xpos_p2;
  logic [1:0]  lights, race_state, winner;
  logic        false_start;

  int checks = 0;
  int errors = 0;

  race_ctrl #(
    .X_START(256), .X_FINISH(300), .COUNT_FRAMES(2),
    .DECAY_FRAMES(4), .SPEED_STEP(2), .SPEED_MAX(15)
  ) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .start(start),
    .p1_key(p1_key), .p2_key(p2_key),
    .xpos_p1(xpos_p1), .xpos_p2(xpos_p2), .lights(lights),
    .race_state(race_state), .winner(winner), .false_start(false_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic frame(input logic k1, input logic k2);
    vsync_in = 1'b1; p1_key = k1; p2_key = k2;
    step();
    vsync_in = 1'b0; p1_key = 1'b0; p2_key = 1'b0;
    step();
    step();
  endtask

  task automatic keys(input logic k1, input logic k2, input int n);
    for (int i = 0; i < n; i++) begin
      p1_key = k1; p2_key = k2;
      step();
      p1_key = 1'b0; p2_key = 1'b0;
      step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic go_race(input string tag);
    pulse_start();
    repeat (6) frame(1'b0, 1'b0);
    chk({tag, "_in_race"}, race_state, 2);
  endtask

  initial begin
    // reset
    repeat (3) step();
    chk("rst_state", race_state, 0);
    chk("rst_x1", xpos_p1, 256);
    chk("rst_lights", lights, 0);
    rst = 1'b1;
    step();
    chk("idle_x2", xpos_p2, 256);
    chk("idle_winner", winner, 0);
    chk("idle_fs", false_start, 0);

    // countdown sequence
    pulse_start();
    chk("cd_state", race_state, 1);
    chk("cd_l0", lights, 3);
    frame(1'b0, 1'b0); chk("cd_l1", lights, 3);
    frame(1'b0, 1'b0); chk("cd_l2", lights, 2);
    frame(1'b0, 1'b0); chk("cd_l3", lights, 2);
    frame(1'b0, 1'b0); chk("cd_l4", lights, 1);
    frame(1'b0, 1'b0); chk("cd_l5", lights, 1);
    frame(1'b0, 1'b0);
    chk("cd_race", race_state, 2);
    chk("cd_lights_go", lights, 0);
    pulse_start();
    chk("race_ignores_start", race_state, 2);

    // single-player race to the line
    keys(1'b1, 1'b0, 3);
    frame(1'b0, 1'b0);
    chk("r1_x1", xpos_p1, 262);
    chk("r1_x2", xpos_p2, 256);
    keys(1'b1, 1'b0, 10);
    frame(1'b0, 1'b0); chk("r2_x1", xpos_p1, 277);
    frame(1'b0, 1'b0); chk("r3_x1", xpos_p1, 292);
    frame(1'b0, 1'b0);
    chk("r4_x1_clamp", xpos_p1, 300);
    chk("r4_state", race_state, 3);
    chk("r4_winner", winner, 1);
    chk("r4_fs", false_start, 0);
    keys(1'b1, 1'b1, 1);
    frame(1'b0, 1'b0);
    chk("fin_hold_x2", xpos_p2, 256);
    chk("fin_hold_winner", winner, 1);
    pulse_start();
    chk("fin_to_idle", race_state, 0);
    chk("fin_idle_x1", xpos_p1, 256);
    chk("fin_idle_winner", winner, 0);

    // false start by player 2 while lights=2
    pulse_start();
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    chk("fs_lights", lights, 2);
    keys(1'b0, 1'b1, 1);
    chk("fs_state", race_state, 3);
    chk("fs_winner", winner, 1);
    chk("fs_flag", false_start, 1);
    chk("fs_x1", xpos_p1, 256);
    chk("fs_x2", xpos_p2, 256);
    pulse_start();
    chk("fs_idle_flag", false_start, 0);

    // both jump together
    pulse_start();
    keys(1'b1, 1'b1, 1);
    chk("fs2_winner", winner, 3);
    pulse_start();

    // start plus key in IDLE: countdown, key ignored
    start = 1'b1; p1_key = 1'b1;
    step();
    start = 1'b0; p1_key = 1'b0;
    chk("idle_key_state", race_state, 1);
    chk("idle_key_fs", false_start, 0);
    repeat (6) frame(1'b0, 1'b0);
    chk("sim_in_race", race_state, 2);

    // simultaneous finish at saturated speed
    keys(1'b1, 1'b1, 8);
    frame(1'b0, 1'b0);
    chk("sim_t1_x1", xpos_p1, 271);
    chk("sim_t1_x2", xpos_p2, 271);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    chk("sim_x1", xpos_p1, 300);
    chk("sim_x2", xpos_p2, 300);
    chk("sim_winner", winner, 3);
    pulse_start();

    // asynchronous reset in the middle of a race
    go_race("rr");
    keys(1'b1, 1'b0, 6);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    chk("rr_x1_before", xpos_p1, 280);
    rst = 1'b0;
    #2;
    chk("rr_state", race_state, 0);
    chk("rr_x1", xpos_p1, 256);
    chk("rr_lights", lights, 0);
    step();
    rst = 1'b1;
    step();
    pulse_start();
    chk("rr_restart_state", race_state, 1);
    chk("rr_restart_lights", lights, 3);
    repeat (6) frame(1'b0, 1'b0);
    chk("dk_in_race", race_state, 2);

    // key pulse landing on the decay tick
    keys(1'b1, 1'b1, 2);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    chk("dk_t4_x1", xpos_p1, 272);
    chk("dk_t4_x2", xpos_p2, 272);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    chk("dk_t7_x1", xpos_p1, 290);
    chk("dk_t7_x2", xpos_p2, 281);
    frame(1'b1, 1'b0);
    chk("dk_t8_x1", xpos_p1, 296);
    chk("dk_t8_x2", xpos_p2, 284);
    frame(1'b0, 1'b0);
    chk("dk_t9_x1", xpos_p1, 300);
    chk("dk_t9_x2", xpos_p2, 286);
    chk("dk_winner", winner, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
